// File: rtl/seg_scan_scheduler.sv
// rtl/seg_scan_scheduler.sv - 4-digit 7-segment scan scheduler with blank gap and frame-synchronous load
// Optional duty control: define SEG_BRIGHTNESS_EN.

module seg_scan_scheduler #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [27:0] seg_in,
    input  logic        load,
    output logic        load_ack,
    input  logic [2:0]  brightness,
    output logic [6:0]  seg_out,
    output logic [3:0]  digit_en,
    output logic        frame_start
);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);

    state_t           state, nxt_state;
    logic [1:0]       idx, nxt_idx;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [27:0]      staging, shadow, nxt_shadow;
    logic             pending;
    logic             boundary, transfer, drive_on;
    logic [6:0]       nxt_seg;

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt + 1'b1;
        boundary  = 1'b0;
        if (!enable) begin
            nxt_state = IDLE;
            nxt_idx   = 2'd0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    boundary  = 1'b1;
                    nxt_idx   = 2'd0;
                    nxt_cnt   = '0;
                    nxt_state = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        nxt_state = DRIVE;
                        nxt_cnt   = '0;
                    end
                end
                DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        nxt_idx   = idx + 1'b1;
                        nxt_cnt   = '0;
                        boundary  = (idx == 2'd3);
                        nxt_state = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_idx   = 2'd0;
                    nxt_cnt   = '0;
                end
            endcase
        end
        // A blanked display still takes new data so it is current on re-enable.
        transfer   = pending && (boundary || (state == IDLE));
        nxt_shadow = transfer ? staging : shadow;
        nxt_seg    = nxt_shadow[nxt_idx*7 +: 7];
    end

`ifdef SEG_BRIGHTNESS_EN
    logic [2:0]       bright_q, nxt_bright;
    logic [CNT_W+3:0] on_prod;

    always_comb begin
        nxt_bright = boundary ? brightness : bright_q;
        on_prod    = ({{(CNT_W+1){1'b0}}, nxt_bright} + 1'b1) * (CNT_W+4)'(DWELL_CYCLES);
        drive_on   = ({4'b0000, nxt_cnt} < (on_prod >> 3));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bright_q <= 3'd0;
        else        bright_q <= nxt_bright;
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign drive_on = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 2'd0;
            cnt         <= '0;
            staging     <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            seg_out     <= '0;
            digit_en    <= '0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= nxt_state;
            idx         <= nxt_idx;
            cnt         <= nxt_cnt;
            shadow      <= nxt_shadow;
            // A load coinciding with a transfer stays pending for the next frame.
            pending     <= load | (pending & ~transfer);
            if (load) staging <= seg_in;
            load_ack    <= transfer;
            frame_start <= boundary;
            if (nxt_state == DRIVE && drive_on) begin
                digit_en <= 4'b0001 << nxt_idx;
                seg_out  <= nxt_seg;
            end else begin
                digit_en <= 4'b0000;
                seg_out  <= 7'd0;
            end
        end
    end

endmodule
